// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROL decomposed into NUM_STAGE
// power-of-two stages, each registered, with bubble-collapsing valid/ready
// flow control and zero / sticky result flags.
module pipelined_barrel_shifter #(
   parameter int NUM_STAGE   = 4,
   parameter bit SRA_FILL_EN = 1'b1,
   localparam int DATA_W     = 2 ** NUM_STAGE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [NUM_STAGE-1:0] in_shamt,
   input  logic [1:0]           in_dir,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_zero,
   output logic                 out_sticky
);

   localparam logic [1:0] DIR_SLL = 2'b00;
   localparam logic [1:0] DIR_SRL = 2'b01;
   localparam logic [1:0] DIR_SRA = 2'b10;

   typedef struct packed {
      logic              sticky;
      logic [DATA_W-1:0] data;
   } stage_res_t;

   // One stage of the shifter: shift by sh when en is set, accumulating the
   // OR of every 1-bit that falls off the word into sticky.
   function automatic stage_res_t stage_op(
      input logic [DATA_W-1:0] d,
      input logic              stk,
      input logic              en,
      input logic [1:0]        dir,
      input int unsigned       sh
   );
      stage_res_t               r;
      logic signed [DATA_W-1:0] sd;
      logic [DATA_W-1:0]        lo_mask;
      logic [DATA_W-1:0]        hi_mask;
      r.data   = d;
      r.sticky = stk;
      sd       = d;
      lo_mask  = ~({DATA_W{1'b1}} << sh);
      hi_mask  = ~({DATA_W{1'b1}} >> sh);
      if (en) begin
         case (dir)
            DIR_SLL: begin
               r.data   = d << sh;
               r.sticky = stk | (|(d & hi_mask));
            end
            DIR_SRL: begin
               r.data   = d >> sh;
               r.sticky = stk | (|(d & lo_mask));
            end
            DIR_SRA: begin
               if (SRA_FILL_EN) begin
                  r.data = sd >>> sh;
               end else begin
                  r.data = d >> sh;
               end
               r.sticky = stk | (|(d & lo_mask));
            end
            default: begin
               // rotate: nothing is lost, sticky is carried unchanged
               r.data = (d << sh) | (d >> (DATA_W - sh));
            end
         endcase
      end
      return r;
   endfunction

   logic [NUM_STAGE-1:0] vld_q, vld_d;
   logic [NUM_STAGE-1:0] stk_q, stk_d;
   logic [DATA_W-1:0]    data_q [NUM_STAGE];
   logic [DATA_W-1:0]    data_d [NUM_STAGE];
   logic [NUM_STAGE-1:0] amt_q  [NUM_STAGE];
   logic [NUM_STAGE-1:0] amt_d  [NUM_STAGE];
   logic [1:0]           dir_q  [NUM_STAGE];
   logic [1:0]           dir_d  [NUM_STAGE];
   logic                 zero_q, zero_d;

   logic [NUM_STAGE-1:0] load;
   logic [NUM_STAGE-1:0] src_vld;
   logic [NUM_STAGE-1:0] src_stk;
   logic [DATA_W-1:0]    src_data [NUM_STAGE];
   logic [NUM_STAGE-1:0] src_amt  [NUM_STAGE];
   logic [1:0]           src_dir  [NUM_STAGE];
   stage_res_t           res      [NUM_STAGE];

   // Stage i may load when the output drains or any slot from i onward is
   // empty, so bubbles collapse even while the output is stalled.
   always_comb begin
      for (int i = 0; i < NUM_STAGE; i++) begin
         load[i] = out_ready;
         for (int j = i; j < NUM_STAGE; j++) begin
            if (!vld_q[j]) begin
               load[i] = 1'b1;
            end
         end
      end
   end

   assign in_ready = load[0];

   // Per-stage shift and next-state selection; payload only moves with a valid.
   always_comb begin
      src_vld[0]  = in_valid;
      src_data[0] = in_data;
      src_amt[0]  = in_shamt;
      src_dir[0]  = in_dir;
      src_stk[0]  = 1'b0;
      for (int i = 1; i < NUM_STAGE; i++) begin
         src_vld[i]  = vld_q[i-1];
         src_data[i] = data_q[i-1];
         src_amt[i]  = amt_q[i-1];
         src_dir[i]  = dir_q[i-1];
         src_stk[i]  = stk_q[i-1];
      end
      for (int i = 0; i < NUM_STAGE; i++) begin
         res[i] = stage_op(src_data[i], src_stk[i], src_amt[i][i], src_dir[i],
                           32'd1 << i);
         vld_d[i]  = vld_q[i];
         data_d[i] = data_q[i];
         stk_d[i]  = stk_q[i];
         amt_d[i]  = amt_q[i];
         dir_d[i]  = dir_q[i];
         if (load[i]) begin
            vld_d[i] = src_vld[i];
            if (src_vld[i]) begin
               data_d[i] = res[i].data;
               stk_d[i]  = res[i].sticky;
               amt_d[i]  = src_amt[i];
               dir_d[i]  = src_dir[i];
            end
         end
      end
      // zero flag comes straight from the last stage's shifted value
      zero_d = zero_q;
      if (load[NUM_STAGE-1] && src_vld[NUM_STAGE-1]) begin
         zero_d = (res[NUM_STAGE-1].data == '0);
      end
   end

   // Stage registers; reset clears every slot so in-flight work is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         stk_q  <= '0;
         zero_q <= 1'b0;
         for (int i = 0; i < NUM_STAGE; i++) begin
            data_q[i] <= '0;
            amt_q[i]  <= '0;
            dir_q[i]  <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         stk_q  <= stk_d;
         zero_q <= zero_d;
         for (int i = 0; i < NUM_STAGE; i++) begin
            data_q[i] <= data_d[i];
            amt_q[i]  <= amt_d[i];
            dir_q[i]  <= dir_d[i];
         end
      end
   end

   assign out_valid  = vld_q[NUM_STAGE-1];
   assign out_data   = data_q[NUM_STAGE-1];
   assign out_sticky = stk_q[NUM_STAGE-1];
   assign out_zero   = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (NUM_STAGE=4). A second
// instance with SRA_FILL_EN=0 shares the inputs to cover zero-filled SRA.
module tb_pipelined_barrel_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready, in_ready0;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic [1:0]  in_dir;
   logic        out_valid, out_valid0;
   logic        out_ready;
   logic [15:0] out_data, out_data0;
   logic        out_zero, out_zero0;
   logic        out_sticky, out_sticky0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.NUM_STAGE(4), .SRA_FILL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_dir(in_dir),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero), .out_sticky(out_sticky)
   );

   pipelined_barrel_shifter #(.NUM_STAGE(4), .SRA_FILL_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_shamt(in_shamt), .in_dir(in_dir),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_zero(out_zero0), .out_sticky(out_sticky0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one transaction (out_ready=1) and check latency and result.
   task automatic send_and_check(input string tag, input logic [15:0] d, input logic [3:0] a,
                                 input logic [1:0] dir, input logic [15:0] exp_d,
                                 input logic exp_s, input logic [15:0] exp_d0);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_shamt  = a;
      in_dir    = dir;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      in_shamt = 4'hF;
      in_dir   = 2'b11;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_data"}, 32'(out_data), 32'(exp_d));
      check({tag, "_sticky"}, 32'(out_sticky), 32'(exp_s));
      check({tag, "_zero"}, 32'(out_zero), 32'(exp_d == 16'h0000));
      check({tag, "_data_nofill"}, 32'(out_data0), 32'(exp_d0));
      @(posedge clk); #1;
      check({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   logic [15:0] stream_exp [10];
   int          sent, recv, t, inflight, quiet_hits, lat;
   bit          held, saw_full;
   logic [15:0] held_d;

   initial begin
      stream_exp = '{16'h0003, 16'h0006, 16'h000C, 16'h0018, 16'h0030,
                     16'h0060, 16'h00C0, 16'h0180, 16'h0300, 16'h0600};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_shamt  = 4'h0;
      in_dir    = 2'b00;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_sticky", 32'(out_sticky), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // single transactions
      send_and_check("sll5",     16'h0080, 4'd5,  2'b00, 16'h1000, 1'b0, 16'h1000);
      send_and_check("srl15",    16'h0080, 4'd15, 2'b01, 16'h0000, 1'b1, 16'h0000);
      send_and_check("sll15",    16'h0080, 4'd15, 2'b00, 16'h0000, 1'b1, 16'h0000);
      send_and_check("sra4",     16'h8000, 4'd4,  2'b10, 16'hF800, 1'b0, 16'h0800);
      send_and_check("rol1",     16'h8001, 4'd1,  2'b11, 16'h0003, 1'b0, 16'h0003);
      send_and_check("sll0",     16'h8001, 4'd0,  2'b00, 16'h8001, 1'b0, 16'h8001);
      send_and_check("sra0",     16'h8001, 4'd0,  2'b10, 16'h8001, 1'b0, 16'h8001);
      send_and_check("sll1_stk", 16'h8001, 4'd1,  2'b00, 16'h0002, 1'b1, 16'h0002);
      send_and_check("sra15",    16'hFFFF, 4'd15, 2'b10, 16'hFFFF, 1'b1, 16'h0001);
      send_and_check("rol15",    16'h8001, 4'd15, 2'b11, 16'hC000, 1'b0, 16'hC000);

      // back-to-back stream with output stalled for cycles 3..8
      sent = 0; recv = 0; t = 0; held = 1'b0; saw_full = 1'b0; held_d = 16'h0000;
      while (recv < 10 && t < 100) begin
         out_ready = !(t >= 3 && t <= 8);
         in_valid  = (sent < 10);
         in_data   = 16'h0003;
         in_shamt  = 4'(sent);
         in_dir    = 2'b00;
         #4;
         if (held) begin
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_data", 32'(out_data), 32'(held_d));
         end
         held   = out_valid && !out_ready;
         held_d = out_data;
         if (in_valid && !in_ready && !saw_full) begin
            saw_full = 1'b1;
            inflight = sent - recv;
            check("stall_full_depth", 32'(inflight), 32'd4);
         end
         if (out_valid && out_ready) begin
            check("stream_data", 32'(out_data), 32'(stream_exp[recv]));
            check("stream_sticky", 32'(out_sticky), 32'd0);
            recv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      check("stream_recv", 32'(recv), 32'd10);
      check("stream_sent", 32'(sent), 32'd10);
      check("stream_backpressure", 32'(saw_full), 32'd1);

      // reset with transactions in flight and a result held at the output
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_dir    = 2'b00;
      in_shamt  = 4'd1;
      for (int k = 0; k < 3; k++) begin
         in_data = 16'h0010 + 16'(k);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("prerst_out_valid", 32'(out_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #4;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      quiet_hits = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) quiet_hits++;
         @(posedge clk); #1;
      end
      check("postrst_no_stale", 32'(quiet_hits), 32'd0);
      send_and_check("postrst", 16'h0101, 4'd8, 2'b11, 16'h0101, 1'b0, 16'h0101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter with four shift modes and valid/ready handshakes on both sides. It performs the same log2-staged mux decomposition as the combinational shifter, but registers each stage, so one result per cycle is sustained at NUM_STAGE cycles latency. It also reports zero and shifted-out (sticky) flags. It sits between a producer and a consumer that may apply backpressure, e.g. the ALU datapath.

Parameters:
NUM_STAGE, 4, number of shift stages; data width DATA_W = 2**NUM_STAGE; shift amount width = NUM_STAGE
SRA_FILL_EN, 1, 1: mode 2 is arithmetic right shift; 0: mode 2 behaves as logical right shift

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  shifter can accept input this cycle
in_data  input  DATA_W  operand
in_shamt  input  NUM_STAGE  shift amount, 0..DATA_W-1
in_dir  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  shifted result
out_zero  output  1  out_data == 0
out_sticky  output  1  OR of all 1-bits shifted out (always 0 for ROL)

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage valid bits 0, out_valid 0, out_data 0, out_zero 0, out_sticky 0. in_ready is combinational and reads 1 out of reset.
- Pipeline: stages 0..NUM_STAGE-1. Stage i shifts by 2**i when shamt bit i is 1, otherwise passes the data through. Each stage has a register holding valid, data, shamt, dir and sticky.
- Per-stage fill rule: stage i loads when it is empty or when stage i+1 loads it this cycle. The last stage drains when out_valid && out_ready. This is bubble-collapsing: a stalled output does not block upstream stages while empty slots remain.
- in_ready = !stage0_valid || stage0_advances. A transfer occurs on in_valid && in_ready. Up to NUM_STAGE results can be in flight.
- out_valid, out_data, out_zero and out_sticky come from the last-stage register. They hold stable while out_valid && !out_ready.
- Latency: an accepted input appears on out_valid exactly NUM_STAGE cycles later if no stall occurs. Throughput is 1 per cycle.
- Per-stage operation at shift s = 2**i:
  - SLL: data << s, zero fill; sticky |= OR(data[DATA_W-1 -: s]).
  - SRL: data >> s, zero fill; sticky |= OR(data[s-1:0]).
  - SRA: data >> s, fill with data[DATA_W-1]; sticky as for SRL. When SRA_FILL_EN = 0, zero fill.
  - ROL: rotate left by s; sticky unchanged (stays 0).
- sticky enters stage 0 as 0.
- out_zero is computed from the final-stage data before registering. It is not delayed.
- Boundaries:
  - in_shamt = 0: data passes unchanged, sticky 0.
  - in_shamt = DATA_W-1: valid for all modes.
  - Simultaneous in-transfer and out-transfer when full: both occur with no loss.
  - in_dir and in_shamt are sampled only on an accepted transfer.
  - rst_n low mid-operation: all in-flight transactions are dropped immediately and out_valid falls asynchronously.
- Ordering: outputs leave strictly in acceptance order. No transaction is duplicated or dropped except by reset.

Test Plan:
- NUM_STAGE=4, in_data=0x0080, in_shamt=5, in_dir=00, out_ready=1 -> 4 cycles later out_valid=1, out_data=0x1000, out_sticky=0, out_zero=0.
- in_data=0x0080, in_shamt=15, in_dir=01 -> out_data=0x0000, out_sticky=1, out_zero=1. Same stimulus with in_dir=00 -> out_data=0x0000, out_sticky=1.
- in_data=0x8000, in_shamt=4, in_dir=10 -> out_data=0xF800, out_sticky=0. Same stimulus with SRA_FILL_EN=0 -> 0x0800.
- in_data=0x8001, in_shamt=1, in_dir=11 -> out_data=0x0003, out_sticky=0. in_shamt=0 -> 0x8001 unchanged.
- Stream of 10 back-to-back transactions while out_ready is held 0 for cycles 3-8 -> in_ready falls once 4 transactions are held. All 10 emerge in order with correct data, and no output changes while stalled.
- Issue 3 transactions, then pull rst_n low for 1 cycle -> out_valid=0 immediately and no stale result appears afterwards. The first post-reset transaction has the normal 4-cycle latency.
